// File: rtl/sync_e1of2_tx.sv
// Clocked-to-asynchronous transmit bridge: queues W-bit flits from a valid/ready
// port and emits them as dual-rail e1of2 tokens under a four-phase enable handshake.
module sync_e1of2_tx #(
    parameter int W           = 9,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2*W-1:0]   out_d,
    input  logic             out_e,
    output logic [15:0]      tx_count,
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        NEUTRAL = 2'd0,
        DATA    = 2'd1,
        WAIT_E  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2*W-1:0]         out_d_q, out_d_d;
    logic [15:0]            tx_count_q, tx_count_d;

    logic [AW:0]            count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   e_s;
    logic [W-1:0]           head;

    function automatic logic [2*W-1:0] encode(input logic [W-1:0] w);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[2*i]   = ~w[i];
            r[2*i+1] = w[i];
        end
        return r;
    endfunction

    // Occupancy comes only from registered pointers, so a same-cycle pop never frees a slot.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = in_valid && !full;
    assign e_s   = sync_q[SYNC_STAGES-1];
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign in_ready  = !full;
    assign out_d     = out_d_q;
    assign tx_count  = tx_count_q;
    assign dbg_state = state_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], out_e};
    end

    always_comb begin
        state_d    = state_q;
        out_d_d    = out_d_q;
        tx_count_d = tx_count_q;
        pop        = 1'b0;
        case (state_q)
            NEUTRAL: begin
                if (e_s && !empty) begin
                    pop     = 1'b1;
                    out_d_d = encode(head);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!e_s) begin
                    out_d_d    = '0;
                    tx_count_d = tx_count_q + 16'd1;
                    state_d    = WAIT_E;
                end
            end
            WAIT_E: begin
                if (e_s) begin
                    state_d = NEUTRAL;
                end
            end
            default: begin
                out_d_d = '0;
                state_d = NEUTRAL;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= NEUTRAL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sync_q     <= '0;
            out_d_q    <= '0;
            tx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sync_q     <= sync_d;
            out_d_q    <= out_d_d;
            tx_count_q <= tx_count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers alone.
    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_sync_e1of2_tx.sv
// Bench for sync_e1of2_tx: protocol-level reference model checked every cycle,
// plus directed scenarios with hand-computed dual-rail encodings and latencies.
module tb_sync_e1of2_tx;

    localparam int W     = 9;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] out_d;
    logic           out_e;
    logic [15:0]    tx_count;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;

    logic       e_drive = 1'b0;
    logic       rx_auto = 1'b0;
    logic [1:0] rx_pipe = 2'b00;

    always #5 clk = ~clk;

    sync_e1of2_tx #(.W(W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_d     (out_d),
        .out_e     (out_e),
        .tx_count  (tx_count),
        .dbg_state (dbg_state)
    );

    // Responsive receiver: raises enable two cycles after it sees neutral, drops it after data.
    always @(negedge clk) rx_pipe <= {rx_pipe[0], (out_d == '0)};
    assign out_e = rx_auto ? rx_pipe[1] : e_drive;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding by arithmetic: bit value b contributes (b ? 2 : 1) to its rail pair.
    function automatic logic [2*W-1:0] rails_of(input logic [W-1:0] w);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r = r + ((2*W)'(w[i] ? 2 : 1) << (2*i));
        end
        return r;
    endfunction

    // Model state: queued words, enable history, what the rails carry, completed tokens.
    logic [W-1:0]   m_fifo[$];
    logic [SS-1:0]  m_sync = '0;
    logic [2*W-1:0] m_rails = '0;
    logic [15:0]    m_tokens = '0;
    bit             m_busy = 1'b0;
    bit             m_await = 1'b0;
    int             m_pre;
    logic           m_es;
    bit             m_push;
    logic [W-1:0]   m_word;
    bit             pair_bad;
    logic [2*W-1:0] got_q[$];
    logic [2*W-1:0] prev_d = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_fifo.delete();
            m_sync   = '0;
            m_rails  = '0;
            m_tokens = '0;
            m_busy   = 1'b0;
            m_await  = 1'b0;
        end else begin
            m_es   = m_sync[SS-1];
            m_pre  = m_fifo.size();
            m_push = in_valid && (m_pre < DEPTH);
            m_word = in_data;
            if (m_busy) begin
                if (!m_es) begin
                    m_rails  = '0;
                    m_tokens = m_tokens + 16'd1;
                    m_busy   = 1'b0;
                    m_await  = 1'b1;
                end
            end else if (m_await) begin
                if (m_es) m_await = 1'b0;
            end else if (m_es && m_pre > 0) begin
                m_rails = rails_of(m_fifo.pop_front());
                m_busy  = 1'b1;
            end
            if (m_push) m_fifo.push_back(m_word);
            m_sync = {m_sync[SS-2:0], out_e};
        end
        #1;
        check("model_out_d", 32'(out_d), 32'(m_rails));
        check("model_tx_count", 32'(tx_count), 32'(m_tokens));
        check("model_in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH));
        if (out_d != '0) begin
            pair_bad = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (out_d[2*i+1] == out_d[2*i]) pair_bad = 1'b1;
            end
            check("rail_pair_onehot", 32'(pair_bad), 32'd0);
            if (prev_d == '0) got_q.push_back(out_d);
        end
        prev_d = out_d;
    end

    task automatic push_word(input logic [W-1:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_tx(input logic [15:0] target, input int budget, input string name);
        int n = 0;
        while (tx_count !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(tx_count), 32'(target));
    endtask

    logic [W-1:0]   burst [5] = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
    logic [2*W-1:0] burst_enc [4] = '{18'h15656, 18'h15959, 18'h15A5A, 18'h16565};
    logic [W-1:0]   b2b [3] = '{9'h000, 9'h1FF, 9'h155};
    logic [2*W-1:0] b2b_enc [3] = '{18'h15555, 18'h2AAAA, 18'h26666};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_out_d", 32'(out_d), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_tx_count", 32'(tx_count), 32'd0);

        // Basic token with the enable already synchronized high.
        e_drive = 1'b1;
        repeat (SS + 1) @(negedge clk);
        push_word(9'h1A5);
        check("basic_before_pop", 32'(out_d), 32'd0);
        @(negedge clk);
        check("basic_data", 32'(out_d), 32'h29966);
        e_drive = 1'b0;
        repeat (2) @(negedge clk);
        check("basic_hold", 32'(out_d), 32'h29966);
        @(negedge clk);
        check("basic_neutral", 32'(out_d), 32'd0);
        check("basic_tx_count", 32'(tx_count), 32'd1);

        // Fill the FIFO with enable low; the fifth word must be refused.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) check("full_ready_low", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            in_data  = burst[k];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("full_fifth_refused", 32'(in_ready), 32'd0);
        got_q.delete();
        rx_auto = 1'b1;
        wait_tx(16'd5, 300, "full_drain_tx_count");
        repeat (6) @(negedge clk);
        check("full_token_count", 32'(got_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) check("full_order", 32'(got_q[k]), 32'(burst_enc[k]));
        end

        // Back-to-back stream through the responsive receiver.
        got_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b2b[k];
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_tx(16'd8, 300, "b2b_tx_count");
        repeat (6) @(negedge clk);
        check("b2b_token_count", 32'(got_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_q.size()) check("b2b_encoding", 32'(got_q[k]), 32'(b2b_enc[k]));
        end

        // Reset while a token is on the rails with another word queued behind it.
        rx_auto = 1'b0;
        e_drive = 1'b1;
        repeat (SS + 2) @(negedge clk);
        push_word(9'h0AB);
        @(negedge clk);
        check("midreset_data", 32'(out_d), 32'(rails_of(9'h0AB)));
        push_word(9'h0CD);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_out_d", 32'(out_d), 32'd0);
        check("midreset_tx_count", 32'(tx_count), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Enable high with an empty FIFO: rails must stay neutral.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_neutral", 32'(out_d), 32'd0);
        end
        push_word(9'h0FF);
        @(negedge clk);
        check("idle_then_data", 32'(out_d), 32'h1AAAA);
        e_drive = 1'b0;
        repeat (SS + 2) @(negedge clk);
        check("idle_final_neutral", 32'(out_d), 32'd0);
        check("idle_final_tx_count", 32'(tx_count), 32'd1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
